// File: rtl/tdm_demux8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Purpose  : Shared types, constants and helpers for the 8-lane TDM link
//             (receive demux and the matching transmit mux).
//  Revision : 1.0  initial release
// ============================================================================
package tdm_pkg;

    // Default number of lanes / time slots per frame
    localparam int TDM_LANES = 8;

    // Frame-alignment state of the receiver
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Even parity bit over a data word (zero-extended, so it holds for up
    // to 64 lanes): the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] vec);
        return ^vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_demux8_if.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux8_if
//  Purpose  : Serial-side inputs and parallel-side outputs of the TDM
//             receiver. master = stimulus / link side, slave = receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface tdm_demux8_if #(
    parameter int LANES = 8
);
    localparam int SLOT_W = $clog2(LANES);

    logic              en;
    logic              din;
    logic              frame_sync;
    logic [LANES-1:0]  out;
    logic              frame_valid;
    logic [SLOT_W-1:0] slot;
    logic              locked;
    logic              resync_err;
    logic              parity_err;

    modport master (
        output en, din, frame_sync,
        input  out, frame_valid, slot, locked, resync_err, parity_err
    );

    modport slave (
        input  en, din, frame_sync,
        output out, frame_valid, slot, locked, resync_err, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux8_slot_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_ctr
//  Purpose  : Wrapping slot counter shared by the TDM mux and demux.
//             clr forces slot 0, restart forces slot 1 (a slot-0 sample
//             was just taken), en advances and wraps after 'wrap'.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_slot_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         restart,
    input  logic [W-1:0] wrap,
    output logic [W-1:0] count
);

    // Slot register: clear has priority over restart, restart over advance
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (restart) begin
            count <= W'(1);
        end else if (en) begin
            count <= (count == wrap) ? '0 : count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux8
//  Purpose  : Receive end of the LANES-slot TDM link. Steers each enabled
//             serial sample into a shadow word, publishes the completed
//             frame on 'out' with a one-cycle frame_valid, tracks frame
//             alignment and flags sync violations.
//  Options  : TDM_DEMUX_PARITY_EN - adds an even-parity slot after the
//             data slots and drives parity_err on a mismatch.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int LANES = TDM_LANES
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux8_if.slave  bus
);

    localparam int SLOT_W = $clog2(LANES);

`ifdef TDM_DEMUX_PARITY_EN
    // One extra slot carries parity, so the counter needs an extra bit
    localparam int                CNT_W = SLOT_W + 1;
    localparam logic [CNT_W-1:0]  WRAP  = CNT_W'(LANES);
`else
    localparam int                CNT_W = SLOT_W;
    localparam logic [CNT_W-1:0]  WRAP  = CNT_W'(LANES - 1);
`endif

    state_t            state, state_nxt;
    logic [LANES-1:0]  shadow, shadow_nxt;
    logic [LANES-1:0]  out_r, out_nxt;
    logic              fv_r, fv_nxt;
    logic              rerr_r, rerr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              ctr_inc, ctr_clr, ctr_restart;
`ifdef TDM_DEMUX_PARITY_EN
    logic              perr_r, perr_nxt;
`endif

    tdm_slot_ctr #(
        .W (CNT_W)
    ) u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ctr_inc),
        .clr     (ctr_clr),
        .restart (ctr_restart),
        .wrap    (WRAP),
        .count   (cnt)
    );

    // Next-state, shadow steering and output pulses; nothing moves while en=0
    always_comb begin
        state_nxt   = state;
        shadow_nxt  = shadow;
        out_nxt     = out_r;
        fv_nxt      = 1'b0;
        rerr_nxt    = 1'b0;
        ctr_inc     = 1'b0;
        ctr_clr     = 1'b0;
        ctr_restart = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        perr_nxt    = 1'b0;
`endif
        if (bus.en) begin
            case (state)
                IDLE: begin
                    // Hunt for a slot-0 sample; everything else is dropped
                    if (bus.frame_sync) begin
                        shadow_nxt = LANES'(bus.din);
                        ctr_inc    = 1'b1;
                        state_nxt  = RUN;
                    end
                end
                RUN: begin
                    if (bus.frame_sync) begin
                        // New frame starts: stale partial bits are discarded
                        shadow_nxt = LANES'(bus.din);
                        if (cnt != '0) begin
                            rerr_nxt    = 1'b1;
                            ctr_restart = 1'b1;
                        end else begin
                            ctr_inc = 1'b1;
                        end
                    end else if (cnt == '0) begin
                        // Slot 0 arrived without sync: alignment lost
                        rerr_nxt  = 1'b1;
                        ctr_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ctr_inc = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                        if (cnt == WRAP) begin
                            out_nxt  = shadow;
                            fv_nxt   = 1'b1;
                            perr_nxt = (even_parity(64'(shadow)) != bus.din);
                        end else begin
                            shadow_nxt[cnt[SLOT_W-1:0]] = bus.din;
                        end
`else
                        shadow_nxt[cnt] = bus.din;
                        // Last data slot: publish the frame including this bit
                        if (cnt == WRAP) begin
                            out_nxt = shadow_nxt;
                            fv_nxt  = 1'b1;
                        end
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, shadow and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            out_r  <= '0;
            fv_r   <= 1'b0;
            rerr_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            out_r  <= out_nxt;
            fv_r   <= fv_nxt;
            rerr_r <= rerr_nxt;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Parity error pulse register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_r <= 1'b0;
        end else begin
            perr_r <= perr_nxt;
        end
    end
    assign bus.parity_err = perr_r;
`else
    assign bus.parity_err = 1'b0;
`endif

    // The parity slot (counter value LANES) shows as slot 0
    assign bus.slot        = cnt[SLOT_W-1:0];
    assign bus.out         = out_r;
    assign bus.frame_valid = fv_r;
    assign bus.resync_err  = rerr_r;
    assign bus.locked      = (state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux8
//  Purpose  : Directed self-checking bench for tdm_demux8 (8 lanes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tdm_demux8_if #(.LANES(8)) bus ();

    tdm_demux8 #(.LANES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vec = 0;
    int err = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int rs_cnt = 0;
    int last_fv = 0;
    int fv_gap = 0;

    // Expected wire bits of a frame: data in slots 0..7, even parity in slot 8
    function automatic logic [8:0] fbits(input logic [7:0] v);
        return {^v, v};
    endfunction

    // One clock: drive inputs, take the edge, observe 1 time unit later
    task automatic tick(input logic e, input logic d, input logic fs);
        bus.en = e;
        bus.din = d;
        bus.frame_sync = fs;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            fv_gap = cyc - last_fv;
            last_fv = cyc;
        end
        if (bus.resync_err === 1'b1) rs_cnt++;
    endtask

    task automatic send_slots(input logic [7:0] v, input int from, input int to);
        logic [8:0] fb;
        fb = fbits(v);
        for (int i = from; i <= to; i++) tick(1'b1, fb[i], (i == 0));
    endtask

    task automatic send_frame(input logic [7:0] v);
        send_slots(v, 0, FL - 1);
    endtask

    task automatic test_reset;
        int fv0;
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        vec++; if (bus.out !== 8'h00) begin err++; $display("FAIL reset_out: got %h expected 00", bus.out); end
        vec++; if (bus.frame_valid !== 1'b0) begin err++; $display("FAIL reset_fv: got %b expected 0", bus.frame_valid); end
        vec++; if (bus.slot !== 3'd0) begin err++; $display("FAIL reset_slot: got %0d expected 0", bus.slot); end
        vec++; if (bus.locked !== 1'b0) begin err++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
        vec++; if (bus.resync_err !== 1'b0) begin err++; $display("FAIL reset_rerr: got %b expected 0", bus.resync_err); end
        vec++; if (bus.parity_err !== 1'b0) begin err++; $display("FAIL reset_perr: got %b expected 0", bus.parity_err); end
        rst_n = 1'b1;
        fv0 = fv_cnt;
        repeat (10) tick(1'b1, 1'b1, 1'b0);
        vec++; if (bus.out !== 8'h00) begin err++; $display("FAIL idle_out: got %h expected 00", bus.out); end
        vec++; if (bus.locked !== 1'b0) begin err++; $display("FAIL idle_locked: got %b expected 0", bus.locked); end
        vec++; if (bus.slot !== 3'd0) begin err++; $display("FAIL idle_slot: got %0d expected 0", bus.slot); end
        vec++; if (fv_cnt !== fv0) begin err++; $display("FAIL idle_fv_count: got %0d expected %0d", fv_cnt, fv0); end
    endtask

    task automatic test_single_hot;
        int fv0;
        logic [7:0] exp;
        fv0 = fv_cnt;
        for (int i = 0; i < 8; i++) begin
            exp = 8'h01 << i;
            send_frame(exp);
            vec++; if (bus.out !== exp) begin err++; $display("FAIL hot_out[%0d]: got %h expected %h", i, bus.out, exp); end
            vec++; if (bus.frame_valid !== 1'b1) begin err++; $display("FAIL hot_fv[%0d]: got %b expected 1", i, bus.frame_valid); end
            vec++; if (bus.parity_err !== 1'b0) begin err++; $display("FAIL hot_perr[%0d]: got %b expected 0", i, bus.parity_err); end
            if (i > 0) begin
                vec++; if (fv_gap !== FL) begin err++; $display("FAIL hot_gap[%0d]: got %0d expected %0d", i, fv_gap, FL); end
            end
        end
        vec++; if (fv_cnt - fv0 !== 8) begin err++; $display("FAIL hot_fv_count: got %0d expected 8", fv_cnt - fv0); end
        vec++; if (bus.locked !== 1'b1) begin err++; $display("FAIL hot_locked: got %b expected 1", bus.locked); end
        vec++; if (bus.slot !== 3'd0) begin err++; $display("FAIL hot_slot: got %0d expected 0", bus.slot); end
    endtask

    task automatic test_gapped;
        int fv0;
        logic [8:0] fb;
        logic [2:0] es;
        fv0 = fv_cnt;
        fb = fbits(8'hA5);
        for (int i = 0; i < FL; i++) begin
            tick(1'b1, fb[i], (i == 0));
            if (i < FL - 1) begin
                es = 3'(i + 1);
                vec++; if (bus.slot !== es) begin err++; $display("FAIL gap_slot[%0d]: got %0d expected %0d", i, bus.slot, es); end
                repeat (3) tick(1'b0, ~fb[i], 1'b1);
                vec++; if (bus.slot !== es) begin err++; $display("FAIL gap_hold[%0d]: got %0d expected %0d", i, bus.slot, es); end
                vec++; if (bus.frame_valid !== 1'b0) begin err++; $display("FAIL gap_fv[%0d]: got %b expected 0", i, bus.frame_valid); end
            end
        end
        vec++; if (bus.out !== 8'hA5) begin err++; $display("FAIL gap_out: got %h expected a5", bus.out); end
        vec++; if (bus.frame_valid !== 1'b1) begin err++; $display("FAIL gap_fv_end: got %b expected 1", bus.frame_valid); end
        tick(1'b0, 1'b0, 1'b0);
        vec++; if (bus.frame_valid !== 1'b0) begin err++; $display("FAIL gap_fv_drop: got %b expected 0", bus.frame_valid); end
        vec++; if (bus.out !== 8'hA5) begin err++; $display("FAIL gap_out_hold: got %h expected a5", bus.out); end
        vec++; if (fv_cnt - fv0 !== 1) begin err++; $display("FAIL gap_fv_count: got %0d expected 1", fv_cnt - fv0); end
    endtask

    task automatic test_early_sync;
        int fv0;
        int rs0;
        logic [8:0] fb;
        fv0 = fv_cnt;
        rs0 = rs_cnt;
        fb = fbits(8'h3C);
        send_slots(8'hFF, 0, 4);
        vec++; if (bus.slot !== 3'd5) begin err++; $display("FAIL early_pre_slot: got %0d expected 5", bus.slot); end
        tick(1'b1, fb[0], 1'b1);
        vec++; if (bus.resync_err !== 1'b1) begin err++; $display("FAIL early_rerr: got %b expected 1", bus.resync_err); end
        vec++; if (bus.slot !== 3'd1) begin err++; $display("FAIL early_slot: got %0d expected 1", bus.slot); end
        vec++; if (bus.locked !== 1'b1) begin err++; $display("FAIL early_locked: got %b expected 1", bus.locked); end
        vec++; if (bus.out !== 8'hA5) begin err++; $display("FAIL early_out_hold: got %h expected a5", bus.out); end
        send_slots(8'h3C, 1, FL - 1);
        vec++; if (bus.out !== 8'h3C) begin err++; $display("FAIL early_out: got %h expected 3c", bus.out); end
        vec++; if (bus.frame_valid !== 1'b1) begin err++; $display("FAIL early_fv: got %b expected 1", bus.frame_valid); end
        vec++; if (rs_cnt - rs0 !== 1) begin err++; $display("FAIL early_rerr_count: got %0d expected 1", rs_cnt - rs0); end
        vec++; if (fv_cnt - fv0 !== 1) begin err++; $display("FAIL early_fv_count: got %0d expected 1", fv_cnt - fv0); end
    endtask

    task automatic test_missing_sync;
        send_frame(8'hFF);
        vec++; if (bus.out !== 8'hFF) begin err++; $display("FAIL miss_frame_out: got %h expected ff", bus.out); end
        tick(1'b1, 1'b1, 1'b0);
        vec++; if (bus.resync_err !== 1'b1) begin err++; $display("FAIL miss_rerr: got %b expected 1", bus.resync_err); end
        vec++; if (bus.locked !== 1'b0) begin err++; $display("FAIL miss_locked: got %b expected 0", bus.locked); end
        vec++; if (bus.slot !== 3'd0) begin err++; $display("FAIL miss_slot: got %0d expected 0", bus.slot); end
        vec++; if (bus.out !== 8'hFF) begin err++; $display("FAIL miss_out: got %h expected ff", bus.out); end
        tick(1'b0, 1'b0, 1'b0);
        vec++; if (bus.resync_err !== 1'b0) begin err++; $display("FAIL miss_rerr_drop: got %b expected 0", bus.resync_err); end
        vec++; if (bus.out !== 8'hFF) begin err++; $display("FAIL miss_out_hold: got %h expected ff", bus.out); end
    endtask

    task automatic test_reset_mid_frame;
        send_slots(8'h5A, 0, 3);
        vec++; if (bus.slot !== 3'd4) begin err++; $display("FAIL mid_pre_slot: got %0d expected 4", bus.slot); end
        vec++; if (bus.locked !== 1'b1) begin err++; $display("FAIL mid_pre_locked: got %b expected 1", bus.locked); end
        rst_n = 1'b0;
        tick(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        vec++; if (bus.out !== 8'h00) begin err++; $display("FAIL mid_out: got %h expected 00", bus.out); end
        vec++; if (bus.slot !== 3'd0) begin err++; $display("FAIL mid_slot: got %0d expected 0", bus.slot); end
        vec++; if (bus.locked !== 1'b0) begin err++; $display("FAIL mid_locked: got %b expected 0", bus.locked); end
        vec++; if (bus.frame_valid !== 1'b0) begin err++; $display("FAIL mid_fv: got %b expected 0", bus.frame_valid); end
        send_frame(8'h5A);
        vec++; if (bus.out !== 8'h5A) begin err++; $display("FAIL mid_after_out: got %h expected 5a", bus.out); end
        vec++; if (bus.frame_valid !== 1'b1) begin err++; $display("FAIL mid_after_fv: got %b expected 1", bus.frame_valid); end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity;
        send_slots(8'h07, 0, 7);
        vec++; if (bus.frame_valid !== 1'b0) begin err++; $display("FAIL par_early_fv: got %b expected 0", bus.frame_valid); end
        vec++; if (bus.slot !== 3'd0) begin err++; $display("FAIL par_slot_show: got %0d expected 0", bus.slot); end
        tick(1'b1, 1'b0, 1'b0);
        vec++; if (bus.parity_err !== 1'b1) begin err++; $display("FAIL par_perr: got %b expected 1", bus.parity_err); end
        vec++; if (bus.out !== 8'h07) begin err++; $display("FAIL par_out: got %h expected 07", bus.out); end
        vec++; if (bus.frame_valid !== 1'b1) begin err++; $display("FAIL par_fv: got %b expected 1", bus.frame_valid); end
        tick(1'b0, 1'b0, 1'b0);
        vec++; if (bus.parity_err !== 1'b0) begin err++; $display("FAIL par_perr_drop: got %b expected 0", bus.parity_err); end
        vec++; if (bus.out !== 8'h07) begin err++; $display("FAIL par_out_hold: got %h expected 07", bus.out); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.din = 1'b0;
        bus.frame_sync = 1'b0;
        test_reset();
        test_single_hot();
        test_gapped();
        test_early_sync();
        test_missing_sync();
        test_reset_mid_frame();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
`default_nettype wire
